tile_config_loader: RTL

- Sits directly upstream of the tile switch box and drives its 112-bit configuration bus.
- Accepts a word-serial bitstream over a valid/ready handshake and assembles it into a shadow register.
- Commits the assembled frame to the active register in a single cycle, so the switch box never sees a partial configuration.
- Flags protocol errors and supports abort and restart mid-load.

---
 rtl/tile_config_loader_pkg.sv | 23 ++
 rtl/tile_config_loader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/tile_config_loader_pkg.sv
// Shared definitions for the tile configuration loader: frame geometry,
// loader state encoding and the word-count derivation.
package tile_config_loader_pkg;

    localparam int CONFIG_WIDTH = 112;
    localparam int WORD_WIDTH   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } loader_state_t;

    // Words needed to cover a frame; the last word may carry unused upper bits.
    function automatic int calc_num_words(input int cfg_w, input int word_w);
        return (cfg_w + word_w - 1) / word_w;
    endfunction

    function automatic int calc_count_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage

// File: rtl/tile_config_loader.sv
// Assembles a word-serial bitstream into a shadow frame and commits it to the
// switch-box configuration bus in a single cycle.
module tile_config_loader
    import tile_config_loader_pkg::*;
#(
    parameter int CONFIG_WIDTH = tile_config_loader_pkg::CONFIG_WIDTH,
    parameter int WORD_WIDTH   = tile_config_loader_pkg::WORD_WIDTH
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    load_start,
    input  logic                    abort,
    input  logic [WORD_WIDTH-1:0]   word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_valid,
    output logic                    busy,
    output logic                    error
);

    localparam int NUM_WORDS = calc_num_words(CONFIG_WIDTH, WORD_WIDTH);
    localparam int COUNT_W   = calc_count_width(NUM_WORDS);
    localparam int SHADOW_W  = NUM_WORDS * WORD_WIDTH;
    localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(NUM_WORDS - 1);

    loader_state_t         state, state_nxt;
    logic [COUNT_W-1:0]    count;
    logic [SHADOW_W-1:0]   shadow;

    logic accept;
    logic count_clr;
    logic err_set;
    logic err_clr;
    logic commit;

    // Next-state and per-cycle control decode
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        count_clr = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        commit    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (load_start) begin
                    state_nxt = ST_LOAD;
                    count_clr = 1'b1;
                    err_clr   = 1'b1;
                end else if (word_valid) begin
                    err_set = 1'b1;
                end
            end
            ST_LOAD: begin
                // Restart beats abort, and both suppress any word offered this cycle.
                if (load_start) begin
                    count_clr = 1'b1;
                end else if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (word_valid) begin
                    accept = 1'b1;
                    if (count == LAST_IDX) begin
                        state_nxt = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                commit    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign word_ready = (state == ST_LOAD);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= ST_IDLE;
            count <= '0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (count_clr) begin
                count <= '0;
            end else if (accept) begin
                count <= count + COUNT_W'(1);
            end
            if (err_clr) begin
                error <= 1'b0;
            end else if (err_set) begin
                error <= 1'b1;
            end
        end
    end

    // Shadow frame: word 0 lands in the least significant bits
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            shadow <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (count == COUNT_W'(i)) begin
                    shadow[i*WORD_WIDTH +: WORD_WIDTH] <= word_in;
                end
            end
        end
    end

    // Active frame: whole-frame update only, bits above CONFIG_WIDTH are dropped
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            config_out   <= '0;
            config_valid <= 1'b0;
        end else if (commit) begin
            config_out   <= shadow[CONFIG_WIDTH-1:0];
            config_valid <= 1'b1;
        end
    end

endmodule
